core_dispatch_scheduler: RTL and testbench

CORE_DISPATCH_SCHEDULER -- requirements
Module: coreDispatchScheduler

---
 rtl/core_dispatch_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_core_dispatch_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dispatch_scheduler.sv
// core_dispatch_scheduler
//   Streams a batch of graph jobs to NUM_CORES connected-count cores. Jobs are
//   handed out round-robin and skip cores that signal back-pressure. The block
//   counts jobs in flight, accumulates the connect counts returned by the cores,
//   and reports completion once every job in the batch has come back.
//
// Ports
//   clk, rst              clock; synchronous active-low reset
//   start                 begin a batch (only honoured in IDLE)
//   botValid/botGraph/botLast/botReady   job stream handshake
//   coreValid, coreGraph  one-hot write strobe and broadcast graph (1-cycle latency)
//   coreSlowDown          per-core almost-full back-pressure
//   coreResultValid, coreConnectCount, coreEcc   per-core result returns
//   busy, done            batch in progress / one-cycle completion pulse
//   totalConnect, jobCount   batch accumulators (held until the next start)
//   eccError, protocolError  sticky error flags for the current batch
//
// Optional feature
//   CORE_DISPATCH_STALL_COUNTER_EN adds output stallCycles, a saturating count of
//   DISPATCH cycles where a job was offered but could not be accepted.
module core_dispatch_scheduler #(
  parameter int NUM_CORES         = 4,
  parameter int SUM_WIDTH         = 48,
  parameter int OUTSTANDING_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     botValid,
  input  logic [127:0]             botGraph,
  input  logic                     botLast,
  output logic                     botReady,
  output logic [NUM_CORES-1:0]     coreValid,
  output logic [127:0]             coreGraph,
  input  logic [NUM_CORES-1:0]     coreSlowDown,
  input  logic [NUM_CORES-1:0]     coreResultValid,
  input  logic [6*NUM_CORES-1:0]   coreConnectCount,
  input  logic [NUM_CORES-1:0]     coreEcc,
  output logic                     busy,
  output logic                     done,
  output logic [SUM_WIDTH-1:0]     totalConnect,
  output logic [31:0]              jobCount,
  output logic                     eccError,
  output logic                     protocolError
`ifdef CORE_DISPATCH_STALL_COUNTER_EN
  ,
  output logic [31:0]              stallCycles
`endif
);

  localparam int PTR_W     = $clog2(NUM_CORES);
  localparam int POP_W     = $clog2(NUM_CORES + 1);
  localparam int RES_SUM_W = 6 + $clog2(NUM_CORES);
  localparam int NET_W     = OUTSTANDING_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                       state;
  state_t                       stateNext;
  logic [PTR_W-1:0]             rr;
  logic [OUTSTANDING_WIDTH-1:0] outstanding;

  logic                         anyFree;
  logic [PTR_W-1:0]             chosen;
  logic [PTR_W-1:0]             nextRr;
  logic [NUM_CORES-1:0]         chosenOneHot;
  logic                         accept;
  logic                         startBatch;
  logic [POP_W-1:0]             retCount;
  logic [RES_SUM_W-1:0]         retSum;
  logic signed [NET_W-1:0]      netOut;
  logic                         underflow;
  logic [OUTSTANDING_WIDTH-1:0] outNext;

  function automatic logic [POP_W-1:0] popCount(input logic [NUM_CORES-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CORES; i++) c = c + POP_W'(v[i]);
    return c;
  endfunction

  function automatic logic [RES_SUM_W-1:0] sumCounts(input logic [NUM_CORES-1:0]   v,
                                                    input logic [6*NUM_CORES-1:0] cnt);
    logic [RES_SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (v[i]) s = s + RES_SUM_W'(cnt[6*i +: 6]);
    return s;
  endfunction

  // Round-robin pick: scan offsets high to low so the smallest free offset
  // from rr is the one that sticks.
  always_comb begin
    logic [PTR_W:0] idx;
    anyFree = 1'b0;
    chosen  = '0;
    idx     = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = {1'b0, rr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_CORES)) idx = idx - (PTR_W+1)'(NUM_CORES);
      if (!coreSlowDown[idx[PTR_W-1:0]]) begin
        anyFree = 1'b1;
        chosen  = idx[PTR_W-1:0];
      end
    end
  end

  assign nextRr       = (chosen == PTR_W'(NUM_CORES - 1)) ? '0 : chosen + PTR_W'(1);
  assign chosenOneHot = NUM_CORES'(1) << chosen;

  // Ready depends only on registered state and back-pressure, never on botValid.
  assign botReady   = (state == DISPATCH) && anyFree && (outstanding != '1);
  assign accept     = botValid && botReady;
  assign startBatch = (state == IDLE) && start;
  assign busy       = (state == DISPATCH) || (state == DRAIN);
  assign done       = (state == DONE);

  // Net in-flight change; returns beyond what is in flight clamp at zero.
  assign retCount  = popCount(coreResultValid);
  assign retSum    = sumCounts(coreResultValid, coreConnectCount);
  assign netOut    = $signed({2'b00, outstanding}) + $signed(NET_W'(accept))
                     - $signed(NET_W'(retCount));
  assign underflow = netOut < 0;
  assign outNext   = underflow ? '0 : netOut[OUTSTANDING_WIDTH-1:0];

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (start) stateNext = DISPATCH;
      DISPATCH: if (accept && botLast) stateNext = DRAIN;
      DRAIN:    if (outstanding == '0) stateNext = DONE;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Stage boundary: accepted job -> core write strobe and broadcast graph.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      rr            <= '0;
      outstanding   <= '0;
      coreValid     <= '0;
      coreGraph     <= '0;
      totalConnect  <= '0;
      jobCount      <= '0;
      eccError      <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      state     <= stateNext;
      coreValid <= accept ? chosenOneHot : '0;
      if (accept) begin
        coreGraph <= botGraph;
        rr        <= nextRr;
      end
      if (startBatch) begin
        outstanding   <= '0;
        totalConnect  <= '0;
        jobCount      <= '0;
        eccError      <= 1'b0;
        protocolError <= 1'b0;
      end else if (busy) begin
        outstanding  <= outNext;
        totalConnect <= totalConnect + SUM_WIDTH'(retSum);
        if (accept) jobCount <= jobCount + 32'd1;
        if (underflow) protocolError <= 1'b1;
        if (|(coreEcc & coreResultValid)) eccError <= 1'b1;
      end
    end
  end

`ifdef CORE_DISPATCH_STALL_COUNTER_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stallCycles <= '0;
    end else if (startBatch) begin
      stallCycles <= '0;
    end else if ((state == DISPATCH) && botValid && !botReady && (stallCycles != '1)) begin
      stallCycles <= stallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_dispatch_scheduler.sv
// Bench for core_dispatch_scheduler: directed batches with a cycle-level
// reference model compared every cycle, plus hand-computed end-of-batch values.
module tb_core_dispatch_scheduler;
  localparam int N  = 4;
  localparam int SW = 48;
  localparam int OUT_MAX = (1 << 12) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, botValid, botLast, botReady;
  logic [127:0]    botGraph, coreGraph;
  logic [N-1:0]    coreValid, coreSlowDown, coreResultValid, coreEcc;
  logic [6*N-1:0]  coreConnectCount;
  logic            busy, done, eccError, protocolError;
  logic [SW-1:0]   totalConnect;
  logic [31:0]     jobCount;
`ifdef CORE_DISPATCH_STALL_COUNTER_EN
  logic [31:0]     stallCycles;
`endif

  core_dispatch_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .botValid(botValid), .botGraph(botGraph), .botLast(botLast), .botReady(botReady),
    .coreValid(coreValid), .coreGraph(coreGraph), .coreSlowDown(coreSlowDown),
    .coreResultValid(coreResultValid), .coreConnectCount(coreConnectCount), .coreEcc(coreEcc),
    .busy(busy), .done(done), .totalConnect(totalConnect), .jobCount(jobCount),
    .eccError(eccError), .protocolError(protocolError)
`ifdef CORE_DISPATCH_STALL_COUNTER_EN
    , .stallCycles(stallCycles)
`endif
  );

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input logic [127:0] actV, input logic [127:0] expV);
    nChecks++;
    if (actV !== expV) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, actV, expV);
    end
  endtask

  // Reference model: 0=IDLE 1=DISPATCH 2=DRAIN 3=DONE
  int           mState, mOut, mRr;
  logic [SW-1:0] mTotal;
  logic [31:0]  mJob, mStall;
  logic         mEcc, mProt;
  logic [N-1:0] mCv;
  logic [127:0] mGraph;

  task automatic modelReset();
    mState = 0; mOut = 0; mRr = 0; mTotal = '0; mJob = '0; mStall = '0;
    mEcc = 1'b0; mProt = 1'b0; mCv = '0; mGraph = '0;
  endtask

  function automatic bit mReady();
    return (mState == 1) && (coreSlowDown != '1) && (mOut != OUT_MAX);
  endfunction

  task automatic modelStep();
    bit ready, accept, isBusy;
    int chosen, nRet, sum, net, nState;
    if (!rst) begin
      modelReset();
      return;
    end
    ready  = mReady();
    accept = botValid && ready;
    chosen = -1;
    for (int k = 0; k < N; k++)
      if (chosen < 0 && !coreSlowDown[(mRr + k) % N]) chosen = (mRr + k) % N;
    nRet = 0; sum = 0;
    for (int i = 0; i < N; i++)
      if (coreResultValid[i]) begin
        nRet++;
        sum += int'(coreConnectCount[6*i +: 6]);
      end
    isBusy = (mState == 1) || (mState == 2);
    nState = mState;
    case (mState)
      0: if (start) nState = 1;
      1: if (accept && botLast) nState = 2;
      2: if (mOut == 0) nState = 3;
      default: nState = 0;
    endcase
    if (mState == 0 && start) begin
      mOut = 0; mTotal = '0; mJob = '0; mEcc = 1'b0; mProt = 1'b0; mStall = '0;
    end else if (isBusy) begin
      net = mOut + (accept ? 1 : 0) - nRet;
      if (net < 0) begin mOut = 0; mProt = 1'b1; end
      else mOut = net;
      mTotal = mTotal + SW'(sum);
      if ((coreEcc & coreResultValid) != '0) mEcc = 1'b1;
    end
    if (mState == 1 && botValid && !ready && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
    if (accept) begin
      mJob   = mJob + 32'd1;
      mCv    = N'(1) << chosen;
      mGraph = botGraph;
      mRr    = (chosen + 1) % N;
    end else begin
      mCv = '0;
    end
    mState = nState;
  endtask

  task automatic modelCompare();
    check("botReady", 128'(botReady), 128'(mReady()));
    check("coreValid", 128'(coreValid), 128'(mCv));
    check("coreGraph", coreGraph, mGraph);
    check("busy", 128'(busy), 128'(mState == 1 || mState == 2));
    check("done", 128'(done), 128'(mState == 3));
    check("totalConnect", 128'(totalConnect), 128'(mTotal));
    check("jobCount", 128'(jobCount), 128'(mJob));
    check("eccError", 128'(eccError), 128'(mEcc));
    check("protocolError", 128'(protocolError), 128'(mProt));
`ifdef CORE_DISPATCH_STALL_COUNTER_EN
    check("stallCycles", 128'(stallCycles), 128'(mStall));
`endif
  endtask

  bit checkEn = 0;
  bit respEn  = 0;
  int cyc = 0;
  int doneCount = 0;
  logic [N-1:0] cvLog[$];
  typedef struct packed { logic [31:0] due; logic [7:0] core; } ret_t;
  ret_t pend[$];

  // Compare and monitor at the falling edge, then advance the model with the
  // inputs the DUT will sample at the next rising edge.
  initial forever begin
    @(negedge clk);
    if (checkEn) begin
      modelCompare();
      if (done) doneCount++;
      if (coreValid != '0) begin
        cvLog.push_back(coreValid);
        if (respEn)
          for (int i = 0; i < N; i++)
            if (coreValid[i]) pend.push_back('{due: 32'(cyc + 20), core: 8'(i)});
      end
    end
    modelStep();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (respEn) begin
      coreResultValid = '0; coreConnectCount = '0; coreEcc = '0;
      for (int j = pend.size() - 1; j >= 0; j--)
        if (int'(pend[j].due) == cyc) begin
          coreResultValid[pend[j].core] = 1'b1;
          coreConnectCount[6*int'(pend[j].core) +: 6] = 6'd3;
          pend.delete(j);
        end
    end
  endtask

  task automatic sendJob(input logic [127:0] g, input logic last);
    bit ok;
    ok = 0;
    botValid = 1'b1; botGraph = g; botLast = last;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      ok = botReady;
      tick();
    end
    check("job accepted", 128'(ok), 128'(1));
    botValid = 1'b0; botLast = 1'b0;
  endtask

  task automatic waitDone(input int limit);
    bit seen;
    seen = 0;
    for (int t = 0; t < limit && !seen; t++) begin
      @(negedge clk);
      seen = done;
      tick();
    end
    check("done reached", 128'(seen), 128'(1));
  endtask

  task automatic clearResults();
    coreResultValid = '0; coreConnectCount = '0; coreEcc = '0;
  endtask

  task automatic startBatch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [N-1:0] expOrder1 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [N-1:0] expOrder2 [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

  initial begin
    rst = 1'b0; start = 1'b0; botValid = 1'b0; botLast = 1'b0; botGraph = '0;
    coreSlowDown = '0;
    clearResults();
    tick(); tick();
    checkEn = 1;
    check("reset busy", 128'(busy), 128'(0));
    check("reset coreValid", 128'(coreValid), 128'(0));
    check("reset totalConnect", 128'(totalConnect), 128'(0));
    check("reset botReady", 128'(botReady), 128'(0));
    rst = 1'b1;
    tick();

    // Eight back-to-back jobs, each returning count 3 after 20 cycles.
    respEn = 1; cvLog.delete(); doneCount = 0;
    startBatch();
    for (int k = 0; k < 8; k++) sendJob({4{32'hA500_0000 + 32'(k)}}, k == 7);
    waitDone(200);
    tick(); tick();
    check("batch1 doneCount", 128'(doneCount), 128'(1));
    check("batch1 totalConnect", 128'(totalConnect), 128'(24));
    check("batch1 jobCount", 128'(jobCount), 128'(8));
    check("batch1 order size", 128'(cvLog.size()), 128'(8));
    for (int k = 0; k < 8; k++) check("batch1 order", 128'(cvLog[k]), 128'(expOrder1[k]));

    // Cores 0 and 2 throttled: jobs alternate between 1 and 3; all throttled stalls.
    cvLog.delete();
    coreSlowDown = 4'b0101;
    startBatch();
    sendJob(128'h11, 1'b0);
    sendJob(128'h22, 1'b0);
    coreSlowDown = 4'b1111;
    botValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("botReady all slowed", 128'(botReady), 128'(0));
      tick();
    end
    coreSlowDown = 4'b0101;
    sendJob(128'h33, 1'b0);
    sendJob(128'h44, 1'b1);
    waitDone(200);
    for (int k = 0; k < 4; k++) check("batch2 order", 128'(cvLog[k]), 128'(expOrder2[k]));
    check("batch2 totalConnect", 128'(totalConnect), 128'(12));
    check("batch2 jobCount", 128'(jobCount), 128'(4));
`ifdef CORE_DISPATCH_STALL_COUNTER_EN
    check("batch2 stallCycles", 128'(stallCycles), 128'(5));
`endif
    coreSlowDown = '0;

    // All four cores return 63 in one cycle.
    respEn = 0; clearResults();
    startBatch();
    for (int k = 0; k < 4; k++) sendJob(128'(k + 100), 1'b0);
    tick(); tick();
    check("batch3 before total", 128'(totalConnect), 128'(0));
    coreResultValid = 4'hF; coreConnectCount = {4{6'd63}};
    tick();
    clearResults();
    check("batch3 total 252", 128'(totalConnect), 128'(252));
    sendJob(128'h55, 1'b1);
    coreResultValid = 4'b0001;
    tick();
    clearResults();
    waitDone(20);
    check("batch3 protocolError", 128'(protocolError), 128'(0));
    check("batch3 jobCount", 128'(jobCount), 128'(5));

    // ECC: idle result ignored, flag without valid ignored, flag with valid counts.
    coreResultValid = 4'b0001; coreConnectCount = 24'd9; coreEcc = 4'b0001;
    tick();
    clearResults();
    check("idle result ignored total", 128'(totalConnect), 128'(252));
    check("idle ecc ignored", 128'(eccError), 128'(0));
    startBatch();
    sendJob(128'h66, 1'b1);
    coreEcc = 4'b1111;
    tick();
    clearResults();
    check("ecc without valid", 128'(eccError), 128'(0));
    coreResultValid = 4'b0010; coreConnectCount = 24'(5) << 6; coreEcc = 4'b0010;
    tick();
    clearResults();
    check("ecc with valid", 128'(eccError), 128'(1));
    check("batch4 totalConnect", 128'(totalConnect), 128'(5));
    waitDone(20);
    coreResultValid = 4'b0001; coreConnectCount = 24'd7; coreEcc = 4'b0001;
    tick();
    clearResults();
    check("batch4 total held", 128'(totalConnect), 128'(5));
    check("batch4 ecc held", 128'(eccError), 128'(1));

    // Spurious return in DISPATCH, then reset in the middle of DRAIN.
    startBatch();
    coreResultValid = 4'b0001; coreConnectCount = 24'd2;
    tick();
    clearResults();
    check("protocolError set", 128'(protocolError), 128'(1));
    check("spurious count added", 128'(totalConnect), 128'(2));
    sendJob(128'h77, 1'b1);
    tick();
    check("in drain", 128'(busy), 128'(1));
    rst = 1'b0;
    tick();
    check("midreset busy", 128'(busy), 128'(0));
    check("midreset done", 128'(done), 128'(0));
    check("midreset totalConnect", 128'(totalConnect), 128'(0));
    check("midreset jobCount", 128'(jobCount), 128'(0));
    check("midreset protocolError", 128'(protocolError), 128'(0));
    check("midreset coreGraph", coreGraph, 128'(0));
    rst = 1'b1;
    coreResultValid = 4'b0100; coreConnectCount = 24'(3) << 12;
    tick();
    clearResults();
    check("late result ignored", 128'(totalConnect), 128'(0));
    check("late result no error", 128'(protocolError), 128'(0));
    respEn = 1;
    startBatch();
    sendJob(128'h88, 1'b0);
    sendJob(128'h99, 1'b1);
    waitDone(200);
    check("clean totalConnect", 128'(totalConnect), 128'(6));
    check("clean jobCount", 128'(jobCount), 128'(2));
    check("clean protocolError", 128'(protocolError), 128'(0));
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
